uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a 16550-style UART: stores {BI,FE,PE,data} per character,
// with a single-entry holding-register mode, sticky overrun, error tracking and trigger level.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLEAR,
    input  logic          FIFOEN,
    input  logic [1:0]    TRIGLVL,
    input  logic          WRITE,
    input  logic [7:0]    DIN,
    input  logic          PEIN,
    input  logic          FEIN,
    input  logic          BIIN,
    input  logic          READ,
    input  logic          LSRREAD,
    output logic [7:0]    DOUT,
    output logic          PE,
    output logic          FE,
    output logic          BI,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT,
    output logic          OVERRUN,
    output logic          ERRINFIFO,
    output logic          TRIGGER
);

    localparam int unsigned EW = 11;
    localparam int unsigned CW = AW + 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          ovr_q, ovr_d;
    logic          fifoen_q;

    logic [CW-1:0] capacity;
    logic          empty, full;
    logic [EW-1:0] head, wr_entry;
    logic          wr_err, head_err;
    logic          flush, push, pop, ovr_event, overwrite;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    int unsigned   level;

    // Occupancy, transfer qualification and next-state computation
    always_comb begin
        capacity  = fifoen_q ? CW'(DEPTH) : CW'(1);
        empty     = (count_q == '0);
        full      = (count_q == capacity);
        head      = mem_q[rd_ptr_q];
        wr_entry  = {BIIN, FEIN, PEIN, DIN};
        wr_err    = |wr_entry[10:8];
        head_err  = |head[10:8];
        flush     = CLEAR | (FIFOEN != fifoen_q);
        pop       = READ & ~empty;
        push      = WRITE & (~full | pop);
        ovr_event = WRITE & full & ~READ & ~flush;
        overwrite = ovr_event & ~fifoen_q;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Holding-mode overrun replaces the single stored entry in place
            if (overwrite) begin
                mem_we    = 1'b1;
                mem_waddr = rd_ptr_q;
            end
            count_d   = count_q + CW'(push) - CW'(pop);
            err_cnt_d = err_cnt_q + CW'(push & wr_err) - CW'(pop & head_err)
                      + CW'(overwrite & wr_err) - CW'(overwrite & head_err);
        end

        // A same-cycle overrun beats the LSR read that would clear it
        ovr_d = ovr_q;
        if (ovr_event) begin
            ovr_d = 1'b1;
        end else if (LSRREAD) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            ovr_q     <= 1'b0;
            fifoen_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            ovr_q     <= ovr_d;
            fifoen_q  <= FIFOEN;
        end
    end

    // Storage array; contents are masked by EMPTY so no reset is needed
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem_q[mem_waddr] <= wr_entry;
        end
    end

    always_comb begin
        case (TRIGLVL)
            2'b00:   level = 1;
            2'b01:   level = 4;
            2'b10:   level = 8;
            default: level = 14;
        endcase
    end

    assign DOUT      = empty ? 8'h00 : head[7:0];
    assign PE        = ~empty & head[8];
    assign FE        = ~empty & head[9];
    assign BI        = ~empty & head[10];
    assign EMPTY     = empty;
    assign FULL      = full;
    assign COUNT     = count_q;
    assign OVERRUN   = ovr_q;
    assign ERRINFIFO = (err_cnt_q != '0);
    assign TRIGGER   = fifoen_q ? (32'(count_q) >= level) : ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo: FIFO fill/drain, overrun,
// holding mode, error tracking, trigger, clear and reset.
module tb_uart_rx_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLEAR = 1'b0;
    logic        FIFOEN = 1'b1;
    logic [1:0]  TRIGLVL = 2'b11;
    logic        WRITE = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic        PEIN = 1'b0, FEIN = 1'b0, BIIN = 1'b0;
    logic        READ = 1'b0;
    logic        LSRREAD = 1'b0;
    logic [7:0]  DOUT;
    logic        PE, FE, BI, EMPTY, FULL, OVERRUN, ERRINFIFO, TRIGGER;
    logic [4:0]  COUNT;

    int total = 0;
    int bad   = 0;
    logic [10:0] sb [$];
    int cap = 16;
    bit fifo_mode = 1'b1;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .FIFOEN(FIFOEN), .TRIGLVL(TRIGLVL),
        .WRITE(WRITE), .DIN(DIN), .PEIN(PEIN), .FEIN(FEIN), .BIIN(BIIN),
        .READ(READ), .LSRREAD(LSRREAD), .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
        .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVERRUN(OVERRUN),
        .ERRINFIFO(ERRINFIFO), .TRIGGER(TRIGGER)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        WRITE = 1'b0; READ = 1'b0; LSRREAD = 1'b0; CLEAR = 1'b0;
        PEIN = 1'b0; FEIN = 1'b0; BIIN = 1'b0;
    endtask

    task automatic chk_occ(input string tag);
        chk({tag, ".count"}, 16'(COUNT), 16'(sb.size()));
        chk({tag, ".empty"}, 16'(EMPTY), 16'(sb.size() == 0));
        chk({tag, ".full"},  16'(FULL),  16'(sb.size() == cap));
    endtask

    task automatic wr(input logic [7:0] d, input logic [2:0] st);
        if (sb.size() < cap) sb.push_back({st, d});
        else if (!fifo_mode) sb[0] = {st, d};
        WRITE = 1'b1; DIN = d; {BIIN, FEIN, PEIN} = st;
        tick();
    endtask

    task automatic rd();
        if (sb.size() > 0) chk("head", 16'({BI, FE, PE, DOUT}), 16'(sb.pop_front()));
        else chk("head_empty", 16'({BI, FE, PE, DOUT}), 16'h0);
        READ = 1'b1;
        tick();
    endtask

    task automatic wrrd(input logic [7:0] d);
        if (sb.size() > 0) chk("wrrd_head", 16'({BI, FE, PE, DOUT}), 16'(sb.pop_front()));
        sb.push_back({3'b000, d});
        WRITE = 1'b1; READ = 1'b1; DIN = d;
        tick();
    endtask

    initial begin
        // Reset with FIFO mode requested
        tick(); tick();
        RST = 1'b0;
        chk_occ("rst");
        chk("rst.dout", 16'({BI, FE, PE, DOUT}), 16'h0);
        chk("rst.ovr", 16'(OVERRUN), 16'h0);
        chk("rst.err", 16'(ERRINFIFO), 16'h0);
        chk("rst.trig", 16'(TRIGGER), 16'h0);
        tick();  // registered FIFOEN catches up (flush of empty FIFO)

        // Fill
        for (int i = 0; i < 16; i++) wr(8'(i), 3'b000);
        chk_occ("fill");
        chk("fill.trig14", 16'(TRIGGER), 16'h1);

        // Overrun in FIFO mode
        wr(8'hAA, 3'b000);
        chk("ovr.flag", 16'(OVERRUN), 16'h1);
        chk_occ("ovr");
        chk("ovr.head", 16'(DOUT), 16'h00);
        LSRREAD = 1'b1;
        tick();
        chk("ovr.lsr", 16'(OVERRUN), 16'h0);

        // Push and pop while full
        wrrd(8'h55);
        chk_occ("fullpp");
        chk("fullpp.ovr", 16'(OVERRUN), 16'h0);
        for (int i = 0; i < 16; i++) rd();
        chk_occ("drain");
        rd();
        chk_occ("rd_empty");

        // Holding-register mode
        FIFOEN = 1'b0;
        tick();
        fifo_mode = 1'b0; cap = 1;
        wr(8'h11, 3'b000);
        wr(8'h22, 3'b000);
        chk_occ("hold");
        chk("hold.dout", 16'(DOUT), 16'h22);
        chk("hold.ovr", 16'(OVERRUN), 16'h1);
        chk("hold.trig", 16'(TRIGGER), 16'h1);
        rd();
        chk_occ("hold.rd");
        wrrd(8'h33);
        chk_occ("hold.wrrd_empty");
        chk("hold.wrrd_dout", 16'(DOUT), 16'h33);

        // Back to FIFO mode: mode change flushes but keeps overrun
        FIFOEN = 1'b1;
        tick();
        sb.delete(); fifo_mode = 1'b1; cap = 16;
        chk_occ("modechg");
        chk("modechg.ovr", 16'(OVERRUN), 16'h1);

        // Error tracking and trigger at level 4
        TRIGLVL = 2'b01;
        wr(8'h00, 3'b100);
        chk("err.set", 16'(ERRINFIFO), 16'h1);
        wr(8'h01, 3'b000);
        wr(8'h02, 3'b000);
        chk("trig.3", 16'(TRIGGER), 16'h0);
        wr(8'h03, 3'b000);
        chk("trig.4", 16'(TRIGGER), 16'h1);
        chk("err.bi_head", 16'(BI), 16'h1);
        rd();
        chk("err.clr", 16'(ERRINFIFO), 16'h0);
        chk("trig.after_rd", 16'(TRIGGER), 16'h0);

        // Clear with a simultaneous write
        wr(8'h40, 3'b010);
        wr(8'h41, 3'b000);
        chk_occ("pre_clear");
        chk("pre_clear.ovr", 16'(OVERRUN), 16'h1);
        CLEAR = 1'b1; WRITE = 1'b1; DIN = 8'h77;
        tick();
        sb.delete();
        chk_occ("clear");
        chk("clear.ovr", 16'(OVERRUN), 16'h1);
        chk("clear.err", 16'(ERRINFIFO), 16'h0);
        chk("clear.dout", 16'(DOUT), 16'h0);

        // Reset mid-fill
        for (int i = 0; i < 3; i++) wr(8'(8'hC0 + i), 3'b001);
        chk_occ("midfill");
        RST = 1'b1; WRITE = 1'b1; DIN = 8'hEE;
        tick();
        RST = 1'b0;
        sb.delete();
        chk_occ("rst2");
        chk("rst2.dout", 16'({BI, FE, PE, DOUT}), 16'h0);
        chk("rst2.ovr", 16'(OVERRUN), 16'h0);
        chk("rst2.err", 16'(ERRINFIFO), 16'h0);
        chk("rst2.trig", 16'(TRIGGER), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
